// File: rtl/uart_rx_fifo.sv
// Receive FIFO for a UART: show-ahead head entry, overrun/trigger/RTS status and,
// when UART_RX_TIMEOUT_EN is defined, a character-timeout flag driven by an idle counter.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       wr_perr_i,
    input  logic                       wr_ferr_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [1:0]                 trig_level_i,
    input  logic                       hf_en_i,
    input  logic                       force_rts_i,
    output logic [7:0]                 rd_data_o,
    output logic                       rd_perr_o,
    output logic                       rd_ferr_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overrun_o,
    output logic                       trig_o,
    output logic                       rts_n_o,
    output logic                       timeout_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          trig_q, trig_d;
    logic          rts_n_q, rts_n_d;
    logic          push_ok, pop_ok;
    logic [CW-1:0] thr;
    logic [9:0]    head;

    always_comb begin
        thr = CW'(1);
        case (trig_level_i)
            2'b00:   thr = CW'(1);
            2'b01:   thr = CW'(4);
            2'b10:   thr = CW'(8);
            default: thr = CW'(DEPTH - 2);
        endcase
    end

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        pop_ok    = pop_i && (count_q != '0) && !flush_i;
        push_ok   = wr_valid_i && !flush_i && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
            overrun_d = wr_valid_i && !push_ok;
        end
        trig_d  = (count_d >= thr);
        rts_n_d = hf_en_i && (force_rts_i || (count_d >= thr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            trig_q    <= 1'b0;
            rts_n_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            trig_q    <= trig_d;
            rts_n_q   <= rts_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {wr_ferr_i, wr_perr_i, wr_data_i};
    end

    assign head      = mem_q[rd_ptr_q];
    assign rd_data_o = head[7:0];
    assign rd_perr_o = head[8];
    assign rd_ferr_o = head[9];
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign overrun_o = overrun_q;
    assign trig_o    = trig_q;
    assign rts_n_o   = rts_n_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;

    // The counter saturates at TIMEOUT_CYCLES-1 so the flag holds until activity.
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (push_ok || pop_ok || flush_i) begin
            idle_d    = '0;
            timeout_d = 1'b0;
        end else if (count_q == '0) begin
            idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
        end else begin
            idle_d = idle_q + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of entries; power of two, range 4..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000, giving the idle clk cycles before a character timeout.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports wr_valid_i (in, 1), wr_data_i (in, 8), wr_perr_i (in, 1) and wr_ferr_i (in, 1): the received character plus its parity and stop-bit error flags.
REQ-006 SHALL have ports pop_i (in, 1) and flush_i (in, 1): CPU read strobe and FIFO clear.
REQ-007 SHALL have port trig_level_i, input, 2 bits: trigger threshold select, 00=1, 01=4, 10=8, 11=DEPTH-2.
REQ-008 SHALL have ports hf_en_i (in, 1) and force_rts_i (in, 1): hardware flow-control enable and forced RTS deassert.
REQ-009 SHALL have ports rd_data_o (out, 8), rd_perr_o (out, 1) and rd_ferr_o (out, 1): the head entry.
REQ-010 SHALL have status ports empty_o (1), full_o (1), count_o ($clog2(DEPTH)+1), overrun_o (1), trig_o (1), rts_n_o (1) and timeout_o (1), all outputs.

Function
REQ-011 SHALL store 10-bit entries {ferr, perr, data} in a circular buffer with read/write pointers that wrap modulo DEPTH.
REQ-012 SHALL present the head entry show-ahead on rd_data_o/rd_perr_o/rd_ferr_o whenever empty_o=0; the value is don't-care when empty.
REQ-013 SHALL accept a push on a clk edge with wr_valid_i=1 and count<DEPTH: the entry is written, the write pointer advances and count increments, all visible the next cycle.
REQ-014 SHALL accept a pop on a clk edge with pop_i=1 and count>0: the read pointer advances and count decrements; pop when empty is ignored with no pointer change.
REQ-015 SHALL, on push when full with no pop, drop the incoming character, leave pointers unchanged and pulse overrun_o high for exactly one cycle.
REQ-016 SHALL, on simultaneous push and pop when full, accept both with count unchanged and no overrun.
REQ-017 SHALL, on simultaneous push and pop when empty, accept the push and ignore the pop, giving count=1.
REQ-018 SHALL give flush_i highest priority: pointers and count go to 0 next cycle, and any same-cycle push/pop is discarded without overrun.
REQ-019 SHALL derive empty_o=(count==0), full_o=(count==DEPTH) and trig_o=(count>=threshold) from the registered count only, with no combinational input-to-output path.
REQ-020 SHALL drive rts_n_o from a register: 0 when hf_en_i=0; when hf_en_i=1, 1 if force_rts_i=1 or next-count>=threshold, else 0.

Reset
REQ-021 SHALL, while rst=1, force pointers=0, count_o=0, empty_o=1, full_o=0, overrun_o=0, trig_o=0, rts_n_o=0, timeout_o=0 and timeout counter=0.
REQ-022 SHALL treat rst asserted mid-operation as an immediate abort: contents are lost and no overrun or timeout pulse is produced.
REQ-023 SHALL take its first push on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL compile the character-timeout feature in only when macro UART_RX_TIMEOUT_EN is defined.
REQ-025 SHALL, with UART_RX_TIMEOUT_EN defined, use an idle counter that clears on push, pop, flush or empty, and increments each cycle otherwise.
REQ-026 SHALL, with UART_RX_TIMEOUT_EN defined, set timeout_o when the idle counter reaches TIMEOUT_CYCLES-1 and hold it until the next push, pop or flush.
REQ-027 SHALL, without UART_RX_TIMEOUT_EN, tie timeout_o to 0 and instantiate no counter logic.

Verification
REQ-028 SHALL cover ordering: push 0x11, 0x22, 0x33 -> rd_data_o shows 0x11, 0x22, 0x33 across three pops, then empty_o=1 and count_o=0.
REQ-029 SHALL cover overrun: fill 16 entries, push 0xAA -> full_o=1, a one-cycle overrun_o pulse, and 0xAA never read back; then push+pop in the same cycle -> count stays 16, overrun_o=0.
REQ-030 SHALL cover threshold and RTS: trig_level_i=01, hf_en_i=1, push 4 -> trig_o=1 and rts_n_o=1; pop 1 -> both 0; force_rts_i=1 -> rts_n_o=1 at count 0.
REQ-031 SHALL cover flush with push: count 5, flush_i and wr_valid_i together -> count_o=0 next cycle, empty_o=1, overrun_o=0.
REQ-032 SHALL cover timeout with UART_RX_TIMEOUT_EN and TIMEOUT_CYCLES=10: push 1 and idle -> timeout_o=1 on the 10th idle cycle, cleared by a pop; without the macro, timeout_o stays 0.
REQ-033 SHALL cover reset mid-fill: rst at count 7 -> all outputs at their reset values asynchronously; then push 0x5A -> rd_data_o=0x5A, count_o=1.
